// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: parallel-in/serial-out shift register with frame control.
// A word is captured in one load cycle and then emitted one bit per
// shift-enabled clock, MSB-first (dir=0) or LSB-first (dir=1).
// Optional feature macro: PISO_PARITY_EN appends a parity bit to each frame.
//
// state  | meaning
// IDLE   | waiting for load; ready=1
// SHIFT  | emitting data bits, one per shift=1 cycle
// PARITY | emitting the trailing parity bit (PISO_PARITY_EN only)
module piso_shift_ctrl #(
   parameter int   WIDTH      = 8,
   parameter logic FILL       = 1'b0,
   parameter bit   PARITY_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             dir,
   input  logic             shift,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] load_reg;
   logic             dir_q;
   logic [CW-1:0]    cnt;

`ifdef PISO_PARITY_EN
   logic             par_q;
`else
   logic             unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   // ready is a pure decode of state so it rises as soon as rst asserts
   assign ready = (state == IDLE);

   // frame sequencer: capture, shift out, flag the last bit of the frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         load_reg  <= '0;
         dir_q     <= 1'b0;
         cnt       <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  load_reg <= in;
                  dir_q    <= dir;
                  cnt      <= CW'(WIDTH);
                  state    <= SHIFT;
`ifdef PISO_PARITY_EN
                  par_q    <= (^in) ^ PARITY_ODD;
`endif
               end
            end
            SHIFT: begin
               if (shift) begin
                  out       <= dir_q ? load_reg[0] : load_reg[WIDTH-1];
                  out_valid <= 1'b1;
                  cnt       <= cnt - CW'(1);
                  load_reg  <= dir_q ? {FILL, load_reg[WIDTH-1:1]}
                                     : {load_reg[WIDTH-2:0], FILL};
                  if (cnt == CW'(1)) begin
`ifdef PISO_PARITY_EN
                     state <= PARITY;
`else
                     done  <= 1'b1;
                     state <= IDLE;
`endif
                  end
               end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
               if (shift) begin
                  out       <= par_q;
                  out_valid <= 1'b1;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench for piso_shift_ctrl: a WIDTH=4 and a WIDTH=8 instance, each frame
// checked cycle by cycle against an expected bit list built from the word.
module tb_piso_shift_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load4 = 1'b0, shift4 = 1'b0, dir4 = 1'b0;
   logic       load8 = 1'b0, shift8 = 1'b0, dir8 = 1'b0;
   logic [3:0] in4 = '0;
   logic [7:0] in8 = '0;
   logic       ready4, out4, valid4, done4;
   logic       ready8, out8, valid8, done8;

   int n_assert = 0;
   int n_fail   = 0;
   int sel_w    = 8;
   logic last_out [2];

   logic o_ready, o_out, o_valid, o_done;
   assign o_ready = (sel_w == 4) ? ready4 : ready8;
   assign o_out   = (sel_w == 4) ? out4   : out8;
   assign o_valid = (sel_w == 4) ? valid4 : valid8;
   assign o_done  = (sel_w == 4) ? done4  : done8;

   always #5 clk = ~clk;

   piso_shift_ctrl #(.WIDTH(4), .FILL(1'b0), .PARITY_ODD(1'b0)) dut4 (
      .clk(clk), .rst(rst), .load(load4), .in(in4), .dir(dir4), .shift(shift4),
      .ready(ready4), .out(out4), .out_valid(valid4), .done(done4));

   piso_shift_ctrl #(.WIDTH(8), .FILL(1'b0), .PARITY_ODD(1'b0)) dut8 (
      .clk(clk), .rst(rst), .load(load8), .in(in8), .dir(dir8), .shift(shift8),
      .ready(ready8), .out(out8), .out_valid(valid8), .done(done8));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      if (obs !== expv) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int w, input logic ld, input logic sh,
                        input logic [7:0] word, input logic d);
      if (w == 4) begin
         load4 = ld; shift4 = sh; in4 = word[3:0]; dir4 = d;
         load8 = 1'b0; shift8 = 1'b0;
      end else begin
         load8 = ld; shift8 = sh; in8 = word; dir8 = d;
         load4 = 1'b0; shift4 = 1'b0;
      end
   endtask

   // pat[i] gives shift for the i-th cycle after load (first patlen cycles);
   // with noise, shift is random and load/in/dir are scrambled mid-frame
   task automatic run_frame(input int w, input logic [7:0] word, input logic d,
                            input logic [15:0] pat, input int patlen, input bit noise);
      logic exp_q [$];
      logic e, sh, par;
      int   idx, cyc;
      idx = (w == 4) ? 0 : 1;
      sel_w = w;
      par = 1'b0;
      for (int i = 0; i < w; i++) begin
         e = d ? word[i] : word[w-1-i];
         exp_q.push_back(e);
         par = par ^ e;
      end
`ifdef PISO_PARITY_EN
      exp_q.push_back(par);
`endif
      #0;
      check("ready_before_load", o_ready, 1'b1);
      drive(w, 1'b1, 1'b1, word, d);
      step();
      check("load_valid", o_valid, 1'b0);
      check("load_done", o_done, 1'b0);
      check("load_ready", o_ready, 1'b0);
      check("load_out_hold", o_out, last_out[idx]);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
         if (cyc < patlen) sh = pat[cyc];
         else if (noise)   sh = ($urandom_range(0, 3) != 0);
         else              sh = 1'b1;
         if (noise) drive(w, 1'b1, sh, 8'($urandom), 1'($urandom));
         else       drive(w, 1'b0, sh, word, d);
         step();
         if (sh) begin
            e = exp_q.pop_front();
            check("bit", o_out, e);
            check("bit_valid", o_valid, 1'b1);
            check("bit_done", o_done, (exp_q.size() == 0));
            check("bit_ready", o_ready, (exp_q.size() == 0));
            last_out[idx] = e;
         end else begin
            check("gap_out_hold", o_out, last_out[idx]);
            check("gap_valid", o_valid, 1'b0);
            check("gap_done", o_done, 1'b0);
            check("gap_ready", o_ready, 1'b0);
         end
         cyc++;
      end
      drive(w, 1'b0, 1'b0, word, d);
      check("frame_timeout", exp_q.size(), 0);
      step();
      check("after_done", o_done, 1'b0);
      check("after_valid", o_valid, 1'b0);
      check("after_ready", o_ready, 1'b1);
   endtask

   initial begin
      logic exp_b;
      last_out[0] = 1'b0;
      last_out[1] = 1'b0;
      #2;
      check("rst_ready8", ready8, 1'b1);
      check("rst_out8", out8, 1'b0);
      check("rst_valid8", valid8, 1'b0);
      check("rst_done8", done8, 1'b0);
      check("rst_ready4", ready4, 1'b1);
      check("rst_out4", out4, 1'b0);
      step();
      step();
      @(negedge clk);
      rst = 1'b0;
      step();

      // T1 / T2: WIDTH=4, 1011, both directions, continuous shift
      run_frame(4, 8'h0B, 1'b0, 16'h0, 0, 1'b0);
      run_frame(4, 8'h0B, 1'b1, 16'h0, 0, 1'b0);
      // T3: gaps in shift
      run_frame(8, 8'hC3, 1'b0, 16'b1111011001, 10, 1'b0);
      // T4: load/in/dir noise during the frame must be ignored
      run_frame(8, 8'h0F, 1'b0, 16'hFFFF, 16, 1'b1);
      // T6 stimulus (parity appended only when the feature is built in)
      run_frame(8, 8'hA5, 1'b0, 16'h0, 0, 1'b0);
      run_frame(8, 8'h07, 1'b0, 16'h0, 0, 1'b0);

      // T5: async reset after 3 bits of A5
      sel_w = 8;
      drive(8, 1'b1, 1'b0, 8'hA5, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(8, 1'b0, 1'b1, 8'hA5, 1'b0);
         step();
         exp_b = (8'hA5 >> (7 - i)) & 8'h01;
         check("pre_rst_bit", out8, exp_b);
      end
      drive(8, 1'b0, 1'b0, 8'hA5, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", ready8, 1'b1);
      check("arst_out", out8, 1'b0);
      check("arst_valid", valid8, 1'b0);
      check("arst_done", done8, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      last_out[0] = 1'b0;
      last_out[1] = 1'b0;
      step();
      check("post_rst_done", done8, 1'b0);
      run_frame(8, 8'h5A, 1'b1, 16'h0, 0, 1'b0);

      // randomized frames on both widths
      for (int f = 0; f < 16; f++) begin
         run_frame((f % 2 == 0) ? 8 : 4, 8'($urandom), 1'($urandom),
                   16'h0, 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
